// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and defaults for the register access arbiter
package reg_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  localparam int N_DEF    = 8;
  localparam int NREQ_DEF = 4;
  localparam int NREG_DEF = 4;

  // Index width that stays at least one bit so single-entry configs still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_access_arbiter_if.sv
// rtl/reg_access_arbiter_if.sv - requester-side bus bundle for the register access arbiter
interface reg_access_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF
);

  localparam int AW = idx_width(NREG);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*N-1:0]  wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [N-1:0]       rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/reg_cell.sv
// rtl/reg_cell.sv - one N-bit bank register with write enable and async reset
module reg_cell #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// rtl/reg_access_arbiter.sv - round-robin arbiter serialising requester accesses to a shared register bank
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF
) (
  input logic                 clk,
  input logic                 rst,
  reg_access_arbiter_if.slave bus
);

  localparam int AW = idx_width(NREG);
  localparam int PW = idx_width(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  arb_state_t      state;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   w_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [N-1:0]    wdata_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rvalid_q;
  logic [N-1:0]    rdata_q;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx_v;
  logic [N-1:0]    rd_mux;
  logic [N-1:0]    bank_q [NREG];

  // First requesting index at or after ptr, wrapping; feeds registers only.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx_v = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && bus.req[idx_v]) begin
        found = 1'b1;
        win   = idx_v;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int g = 0; g < NREG; g++) begin
      if (addr_q == AW'(g)) begin
        rd_mux = bank_q[g];
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_bank
    reg_cell #(.N(N)) u_cell (
      .clk (clk),
      .rst (rst),
      .en  ((state == ACCESS) && we_q && (addr_q == AW'(g))),
      .d   (wdata_q),
      .q   (bank_q[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr_q    <= '0;
      w_q      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          rvalid_q <= '0;
          gnt_q    <= '0;
          if (found) begin
            w_q     <= win;
            we_q    <= bus.we[win];
            addr_q  <= bus.addr[win*AW +: AW];
            wdata_q <= bus.wdata[win*N +: N];
            gnt_q   <= ONE << win;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          gnt_q <= '0;
          if (!we_q) begin
            rdata_q  <= rd_mux;
            rvalid_q <= ONE << w_q;
          end
          ptr_q <= (w_q == PW'(NREQ - 1)) ? '0 : w_q + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb/tb_reg_access_arbiter.sv - directed self-checking bench for reg_access_arbiter
module tb_reg_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_access_arbiter_if #(.N(8), .NREQ(4), .NREG(4)) bus ();

  reg_access_arbiter #(.N(8), .NREQ(4), .NREG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [1:0] a, input logic [7:0] d);
    bus.we[i]          = w;
    bus.addr[i*2 +: 2] = a;
    bus.wdata[i*8 +: 8] = d;
    bus.req[i]         = 1'b1;
  endtask

  // Single requester access; for reads the returned data is checked.
  task automatic do_access(input string tag, input int i, input logic w, input logic [1:0] a,
                           input logic [7:0] d, input logic [7:0] exp_rd);
    set_req(i, w, a, d);
    tick();
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(4'b0001 << i));
    bus.req[i] = 1'b0;
    tick();
    check({tag, "_gnt_clr"}, 32'(bus.gnt), 32'h0);
    if (w) begin
      check({tag, "_rvalid_wr"}, 32'(bus.rvalid), 32'h0);
    end else begin
      check({tag, "_rvalid"}, 32'(bus.rvalid), 32'(4'b0001 << i));
      check({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_rd));
    end
  endtask

  initial begin
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    tick();
    tick();
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_rdata", 32'(bus.rdata), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read back through requester 0.
    do_access("wr_a5", 0, 1'b1, 2'd2, 8'hA5, 8'h00);
    do_access("rd_a5", 0, 1'b0, 2'd2, 8'h00, 8'hA5);
    tick();
    check("rd_a5_rvalid_pulse", 32'(bus.rvalid), 32'h0);
    check("rd_a5_rdata_hold", 32'(bus.rdata), 32'hA5);

    // Fresh pointer, all four reading continuously.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'(i), 8'h00);
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("rr_gnt%0d", g), 32'(bus.gnt), 32'(4'b0001 << (g % 4)));
      check($sformatf("rr_rv_idle%0d", g), 32'(bus.rvalid), 32'h0);
      if (g == 4) bus.req = '0;
      tick();
      check($sformatf("rr_gnt_clr%0d", g), 32'(bus.gnt), 32'h0);
      check($sformatf("rr_rv%0d", g), 32'(bus.rvalid), 32'(4'b0001 << (g % 4)));
    end

    // ptr = 1: lone requester 2 holding req is granted every other cycle.
    set_req(2, 1'b0, 2'd0, 8'h00);
    tick();
    check("solo_gnt_a", 32'(bus.gnt), 32'h4);
    tick();
    check("solo_gap", 32'(bus.gnt), 32'h0);
    tick();
    check("solo_gnt_b", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    tick();

    // ptr = 3 -> requester 1 moves ptr to 2; then 0 and 1 request together.
    do_access("ptr_to2", 1, 1'b0, 2'd0, 8'h00, 8'h00);
    set_req(0, 1'b0, 2'd0, 8'h00);
    set_req(1, 1'b0, 2'd0, 8'h00);
    tick();
    check("p2_first", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    tick();
    tick();
    check("p2_second", 32'(bus.gnt), 32'h2);
    bus.req[1] = 1'b0;
    tick();

    // ptr = 2 -> requester 0 moves ptr to 1; then write/read race on reg 3.
    do_access("ptr_to1", 0, 1'b0, 2'd0, 8'h00, 8'h00);
    set_req(1, 1'b1, 2'd3, 8'h3C);
    set_req(2, 1'b0, 2'd3, 8'h00);
    tick();
    check("race_wr_gnt", 32'(bus.gnt), 32'h2);
    bus.req[1] = 1'b0;
    tick();
    check("race_wr_rv", 32'(bus.rvalid), 32'h0);
    tick();
    check("race_rd_gnt", 32'(bus.gnt), 32'h4);
    bus.req[2] = 1'b0;
    tick();
    check("race_rd_rv", 32'(bus.rvalid), 32'h4);
    check("race_rd_data", 32'(bus.rdata), 32'h3C);

    // Reset landing in the middle of a write.
    set_req(0, 1'b1, 2'd0, 8'hFF);
    tick();
    check("abort_gnt", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_gnt_clr", 32'(bus.gnt), 32'h0);
    check("abort_rv", 32'(bus.rvalid), 32'h0);
    check("abort_rdata", 32'(bus.rdata), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_access("abort_rd", 0, 1'b0, 2'd0, 8'h00, 8'h00);

    // Inputs changed after grant must not leak into the access.
    set_req(0, 1'b1, 2'd1, 8'h11);
    tick();
    check("late_gnt", 32'(bus.gnt), 32'h1);
    bus.wdata[7:0] = 8'h22;
    bus.req[0]     = 1'b0;
    tick();
    do_access("late_rd", 0, 1'b0, 2'd1, 8'h00, 8'h11);
    do_access("wr_55", 0, 1'b1, 2'd1, 8'h55, 8'h00);
    check("wr_keeps_rdata", 32'(bus.rdata), 32'h11);
    do_access("rd_55", 0, 1'b0, 2'd1, 8'h00, 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
